// File: rtl/otter_pkg.sv
// ----------------------------------------------------------------------------
// otter_pkg
//   Shared types for the OTTER MCU control path. Both the multi-cycle control
//   FSM and the control unit decoder import this package. It holds:
//     opcode_t  - RV32I major opcodes (ir[6:0]) handled by the core
//     state_t   - control FSM states
//     F3_*      - funct3 codes that select operations within the SYSTEM opcode
// ----------------------------------------------------------------------------
package otter_pkg;

    typedef enum logic [6:0] {
        LUI    = 7'b0110111,
        AUIPC  = 7'b0010111,
        JAL    = 7'b1101111,
        JALR   = 7'b1100111,
        BRANCH = 7'b1100011,
        LOAD   = 7'b0000011,
        STORE  = 7'b0100011,
        OP_IMM = 7'b0010011,
        OP     = 7'b0110011,
        SYS    = 7'b1110011
    } opcode_t;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_FETCH,
        ST_EXEC,
        ST_WB,
        ST_INTR
    } state_t;

    // funct3 values for the SYSTEM opcode
    localparam logic [2:0] F3_MRET  = 3'b000;
    localparam logic [2:0] F3_CSRRW = 3'b001;
    localparam logic [2:0] F3_CSRRS = 3'b010;
    localparam logic [2:0] F3_CSRRC = 3'b011;

    // True for the register-form CSR read-modify-write instructions.
    function automatic logic is_csr_rw(input logic [2:0] funct);
        return (funct == F3_CSRRW) || (funct == F3_CSRRS) || (funct == F3_CSRRC);
    endfunction

endpackage

// File: rtl/cu_fsm.sv
// ----------------------------------------------------------------------------
// cu_fsm
//   Multi-cycle control FSM for the OTTER MCU. Steps each instruction through
//   fetch, execute and (for loads) writeback, produces the memory, register
//   file, PC and CSR strobes, and enters the trap handler at instruction
//   boundaries when an enabled interrupt is pending.
//
// Parameters
//   INIT_CYCLES     cycles FSM_rst stays high after reset release (>= 1)
//
// Ports
//   FSM_clk         in   system clock, rising edge
//   FSM_rst_n       in   asynchronous active-low reset
//   FSM_opcode      in   ir[6:0]
//   FSM_funct       in   ir[14:12]
//   FSM_intr        in   external interrupt request (level)
//   FSM_mie         in   mstatus.MIE global interrupt enable
//   FSM_imem_ready  in   instruction word valid on memory port 1
//   FSM_dmem_ready  in   data access complete on memory port 2
//   FSM_rst         out  synchronous clear for PC and register file
//   FSM_pc_write    out  PC load enable
//   FSM_reg_write   out  register file write enable
//   FSM_mem_rden1   out  instruction fetch read enable
//   FSM_mem_rden2   out  data read enable
//   FSM_mem_we2     out  data write enable
//   FSM_csr_we      out  CSR write enable
//   FSM_int_taken   out  trap entry this cycle
//   FSM_mret_exec   out  mret executing this cycle
//   FSM_retire      out  one pulse per retired instruction
// ----------------------------------------------------------------------------
module cu_fsm
    import otter_pkg::*;
#(
    parameter int INIT_CYCLES = 2
) (
    input  logic       FSM_clk,
    input  logic       FSM_rst_n,
    input  logic [6:0] FSM_opcode,
    input  logic [2:0] FSM_funct,
    input  logic       FSM_intr,
    input  logic       FSM_mie,
    input  logic       FSM_imem_ready,
    input  logic       FSM_dmem_ready,
    output logic       FSM_rst,
    output logic       FSM_pc_write,
    output logic       FSM_reg_write,
    output logic       FSM_mem_rden1,
    output logic       FSM_mem_rden2,
    output logic       FSM_mem_we2,
    output logic       FSM_csr_we,
    output logic       FSM_int_taken,
    output logic       FSM_mret_exec,
    output logic       FSM_retire
);

    localparam int CNT_W = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(INIT_CYCLES - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] init_cnt_q, init_cnt_d;
    logic             int_pend_q, int_pend_d;
    opcode_t          opcode;

    assign opcode = opcode_t'(FSM_opcode);

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    // NOTE: every signal assigned in an always_comb gets a default at the top
    // so no path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d    = state_q;
        init_cnt_d = '0;

        // Pending interrupt: set by an enabled request, cleared while MIE is
        // low or while the trap is being entered. Clear has priority.
        int_pend_d = int_pend_q | (FSM_intr & FSM_mie);
        if (!FSM_mie || (state_q == ST_INTR)) begin
            int_pend_d = 1'b0;
        end

        unique case (state_q)
            ST_INIT: begin
                init_cnt_d = init_cnt_q + 1'b1;
                if (init_cnt_q == CNT_LAST) begin
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (FSM_imem_ready) begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (opcode == LOAD) begin
                    state_d = ST_WB;
                end else if (FSM_retire) begin
                    // Instruction boundary: the only point a trap may be taken.
                    state_d = int_pend_q ? ST_INTR : ST_FETCH;
                end
            end
            ST_WB: begin
                if (FSM_retire) begin
                    state_d = int_pend_q ? ST_INTR : ST_FETCH;
                end
            end
            ST_INTR: begin
                state_d = ST_FETCH;
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Output decode (combinational from state, opcode, funct and ready)
    // ------------------------------------------------------------------------
    always_comb begin
        FSM_rst       = 1'b0;
        FSM_pc_write  = 1'b0;
        FSM_reg_write = 1'b0;
        FSM_mem_rden1 = 1'b0;
        FSM_mem_rden2 = 1'b0;
        FSM_mem_we2   = 1'b0;
        FSM_csr_we    = 1'b0;
        FSM_int_taken = 1'b0;
        FSM_mret_exec = 1'b0;
        FSM_retire    = 1'b0;

        unique case (state_q)
            ST_INIT: begin
                FSM_rst = 1'b1;
            end
            ST_FETCH: begin
                FSM_mem_rden1 = 1'b1;
            end
            ST_EXEC: begin
                case (opcode)
                    OP, OP_IMM, LUI, AUIPC, JAL, JALR: begin
                        FSM_reg_write = 1'b1;
                        FSM_pc_write  = 1'b1;
                    end
                    BRANCH: begin
                        FSM_pc_write = 1'b1;
                    end
                    LOAD: begin
                        FSM_mem_rden2 = 1'b1;
                    end
                    STORE: begin
                        // Write is held until memory accepts it; the PC only
                        // advances in the accepting cycle.
                        FSM_mem_we2  = 1'b1;
                        FSM_pc_write = FSM_dmem_ready;
                    end
                    SYS: begin
                        if (FSM_funct == F3_MRET) begin
                            FSM_mret_exec = 1'b1;
                            FSM_pc_write  = 1'b1;
                        end else if (is_csr_rw(FSM_funct)) begin
                            FSM_csr_we    = 1'b1;
                            FSM_reg_write = 1'b1;
                            FSM_pc_write  = 1'b1;
                        end else begin
                            FSM_pc_write = 1'b1;
                        end
                    end
                    default: begin
                        // Unsupported opcodes retire as a NOP.
                        FSM_pc_write = 1'b1;
                    end
                endcase
            end
            ST_WB: begin
                FSM_mem_rden2 = 1'b1;
                if (FSM_dmem_ready) begin
                    FSM_reg_write = 1'b1;
                    FSM_pc_write  = 1'b1;
                end
            end
            ST_INTR: begin
                FSM_int_taken = 1'b1;
                FSM_pc_write  = 1'b1;
            end
            default: begin
                FSM_rst = 1'b1;
            end
        endcase

        // Trap entry also loads the PC but is not an instruction retirement.
        FSM_retire = FSM_pc_write && ((state_q == ST_EXEC) || (state_q == ST_WB));
    end

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its _d value from before this edge, independent of order.
    always_ff @(posedge FSM_clk or negedge FSM_rst_n) begin
        if (!FSM_rst_n) begin
            state_q    <= ST_INIT;
            init_cnt_q <= '0;
            int_pend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            int_pend_q <= int_pend_d;
        end
    end

endmodule

// File: tb/tb_cu_fsm.sv
// ----------------------------------------------------------------------------
// tb_cu_fsm
//   Self-checking bench for cu_fsm. The stimulus side walks whole instructions
//   (fetch waits, memory waits, interrupt arrival) and pushes the output vector
//   each cycle should show into a queue; a monitor pops and compares on every
//   falling edge.
// ----------------------------------------------------------------------------
module tb_cu_fsm;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] opcode = '0;
    logic [2:0] funct = '0;
    logic       intr = 1'b0;
    logic       mie = 1'b0;
    logic       imem_ready = 1'b0;
    logic       dmem_ready = 1'b0;

    logic o_rst, o_pc, o_reg, o_rd1, o_rd2, o_we2, o_csr, o_int, o_mret, o_ret;

    cu_fsm #(.INIT_CYCLES(2)) dut (
        .FSM_clk        (clk),
        .FSM_rst_n      (rst_n),
        .FSM_opcode     (opcode),
        .FSM_funct      (funct),
        .FSM_intr       (intr),
        .FSM_mie        (mie),
        .FSM_imem_ready (imem_ready),
        .FSM_dmem_ready (dmem_ready),
        .FSM_rst        (o_rst),
        .FSM_pc_write   (o_pc),
        .FSM_reg_write  (o_reg),
        .FSM_mem_rden1  (o_rd1),
        .FSM_mem_rden2  (o_rd2),
        .FSM_mem_we2    (o_we2),
        .FSM_csr_we     (o_csr),
        .FSM_int_taken  (o_int),
        .FSM_mret_exec  (o_mret),
        .FSM_retire     (o_ret)
    );

    always #5 clk = ~clk;

    // Output vector bit positions
    localparam logic [9:0] E_RST  = 10'b10_0000_0000;
    localparam logic [9:0] E_PC   = 10'b01_0000_0000;
    localparam logic [9:0] E_REG  = 10'b00_1000_0000;
    localparam logic [9:0] E_RD1  = 10'b00_0100_0000;
    localparam logic [9:0] E_RD2  = 10'b00_0010_0000;
    localparam logic [9:0] E_WE2  = 10'b00_0001_0000;
    localparam logic [9:0] E_CSR  = 10'b00_0000_1000;
    localparam logic [9:0] E_INT  = 10'b00_0000_0100;
    localparam logic [9:0] E_MRET = 10'b00_0000_0010;
    localparam logic [9:0] E_RET  = 10'b00_0000_0001;

    logic [9:0] exp_q[$];
    int n_vec = 0;
    int n_bad = 0;

    // Reference interrupt state and stimulus knobs
    bit pend_m    = 1'b0;
    bit last_pend = 1'b0;
    bit rand_irq  = 1'b0;
    bit intr_drv  = 1'b0;
    bit mie_drv   = 1'b1;

    // ------------------------------------------------------------------------
    // Monitor / checker
    // ------------------------------------------------------------------------
    task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s t=%0t got=%b exp=%b (rst,pc,reg,rd1,rd2,we2,csr,int,mret,ret) op=%b f3=%b",
                     name, $time, act, exp, opcode, funct);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            check("outputs",
                  {o_rst, o_pc, o_reg, o_rd1, o_rd2, o_we2, o_csr, o_int, o_mret, o_ret},
                  exp_q.pop_front());
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------------
    function automatic logic rb();
        return logic'($urandom_range(0, 1));
    endfunction

    // One clock cycle: drive inputs, queue the expected outputs, advance the
    // reference interrupt-pending bit, then step to just after the next edge.
    task automatic cyc(input logic imem_r, input logic dmem_r, input logic [9:0] exp,
                       input bit is_intr, input bit is_rst);
        logic i_v, m_v;
        i_v = rand_irq ? ($urandom_range(0, 9) == 0) : intr_drv;
        m_v = rand_irq ? ($urandom_range(0, 5) != 0) : mie_drv;
        intr       = i_v;
        mie        = m_v;
        imem_ready = imem_r;
        dmem_ready = dmem_r;
        exp_q.push_back(exp);
        last_pend = pend_m;
        if (is_rst) pend_m = 1'b0;
        else        pend_m = m_v && !is_intr && (pend_m || i_v);
        @(posedge clk);
        #1;
    endtask

    // Hold reset low for n_low cycles, release, then expect the init window.
    task automatic reset_seq(input int n_low);
        rst_n = 1'b0;
        repeat (n_low) cyc(rb(), rb(), E_RST, 1'b0, 1'b1);
        rst_n = 1'b1;
        repeat (2) cyc(rb(), rb(), E_RST, 1'b0, 1'b0);
    endtask

    // Expected EXEC-cycle outputs for single-cycle execute classes.
    function automatic logic [9:0] exec_vec(input logic [6:0] op, input logic [2:0] f3);
        case (op)
            7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111,
            7'b1101111, 7'b1100111: return E_REG | E_PC | E_RET;
            7'b1100011:             return E_PC | E_RET;
            7'b1110011: begin
                if (f3 == 3'd0)                    return E_MRET | E_PC | E_RET;
                else if (f3 >= 3'd1 && f3 <= 3'd3) return E_CSR | E_REG | E_PC | E_RET;
                else                               return E_PC | E_RET;
            end
            default:                return E_PC | E_RET;
        endcase
    endfunction

    // One full instruction with fw fetch waits and mw data-memory waits,
    // followed by trap entry if an interrupt was pending at retirement.
    task automatic do_instr(input logic [6:0] op, input logic [2:0] f3,
                            input int fw, input int mw);
        opcode = op;
        funct  = f3;
        repeat (fw) cyc(1'b0, rb(), E_RD1, 1'b0, 1'b0);
        cyc(1'b1, rb(), E_RD1, 1'b0, 1'b0);
        if (op == 7'b0000011) begin
            cyc(rb(), rb(), E_RD2, 1'b0, 1'b0);
            repeat (mw) cyc(rb(), 1'b0, E_RD2, 1'b0, 1'b0);
            cyc(rb(), 1'b1, E_RD2 | E_REG | E_PC | E_RET, 1'b0, 1'b0);
        end else if (op == 7'b0100011) begin
            repeat (mw) cyc(rb(), 1'b0, E_WE2, 1'b0, 1'b0);
            cyc(rb(), 1'b1, E_WE2 | E_PC | E_RET, 1'b0, 1'b0);
        end else begin
            cyc(rb(), rb(), exec_vec(op, f3), 1'b0, 1'b0);
        end
        if (last_pend) cyc(rb(), rb(), E_INT | E_PC, 1'b1, 1'b0);
    endtask

    // Load aborted by an asynchronous reset in the middle of writeback.
    task automatic load_abort();
        opcode = 7'b0000011;
        funct  = 3'b010;
        cyc(1'b1, rb(), E_RD1, 1'b0, 1'b0);
        cyc(rb(), rb(), E_RD2, 1'b0, 1'b0);
        cyc(rb(), 1'b0, E_RD2, 1'b0, 1'b0);
        // Still in writeback here; drop reset between edges.
        dmem_ready = 1'b0;
        exp_q.push_back(E_RST);
        #1 rst_n = 1'b0;
        pend_m = 1'b0;
        @(posedge clk);
        #1;
        reset_seq(2);
    endtask

    // ------------------------------------------------------------------------
    // Test sequence
    // ------------------------------------------------------------------------
    logic [6:0] op_tab [13];

    initial begin
        op_tab = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011,
                   7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011, 7'b1110011,
                   7'b0001111, 7'b1111111, 7'b0000000};

        @(posedge clk);
        #1;
        reset_seq(3);

        do_instr(7'b0110011, 3'b000, 0, 0);     // add
        do_instr(7'b0000011, 3'b010, 0, 3);     // lw, 3 WB waits
        do_instr(7'b0100011, 3'b010, 0, 0);     // sw, immediate accept
        do_instr(7'b0100011, 3'b010, 2, 2);     // sw with waits

        intr_drv = 1'b1;                        // interrupt during FETCH of addi
        mie_drv  = 1'b1;
        do_instr(7'b0010011, 3'b000, 1, 0);
        intr_drv = 1'b0;
        do_instr(7'b0010011, 3'b000, 0, 0);

        intr_drv = 1'b1;                        // same stimulus, interrupts masked
        mie_drv  = 1'b0;
        do_instr(7'b0010011, 3'b000, 1, 0);
        intr_drv = 1'b0;
        mie_drv  = 1'b1;

        do_instr(7'b1110011, 3'b001, 0, 0);     // csrrw
        do_instr(7'b1110011, 3'b000, 0, 0);     // mret
        do_instr(7'b1110011, 3'b101, 0, 0);     // unsupported SYS funct -> NOP
        do_instr(7'b1100011, 3'b000, 0, 0);     // branch
        do_instr(7'b1111111, 3'b000, 0, 0);     // illegal opcode -> NOP

        load_abort();
        do_instr(7'b0110111, 3'b000, 0, 0);     // lui after abort

        rand_irq = 1'b1;
        for (int i = 0; i < 300; i++) begin
            do_instr(op_tab[$urandom_range(0, 12)], 3'($urandom_range(0, 7)),
                     $urandom_range(0, 2), $urandom_range(0, 3));
            if ($urandom_range(0, 49) == 0) reset_seq($urandom_range(1, 3));
        end
        rand_irq = 1'b0;
        intr_drv = 1'b0;
        do_instr(7'b0110011, 3'b000, 0, 0);

        @(negedge clk);
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain got=%0d pending exp=0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
